wback_queue: RTL

- Parametrised successor to the single-register writeback stage.
- Sits between the MEM stage and the GPR/CSR register files, and buffers up to DEPTH completed instructions.
- Formats raw load data (sign/zero extension, byte-lane select) as each entry is pushed.
- Retires one entry per handshake, drives the GPR and CSR write ports, and reports RAW hazards against every pending entry to decode.

---
 rtl/wback_queue_pkg.sv | 22 ++
 rtl/wback_load_fmt.sv | 41 ++++
 rtl/wback_queue.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/wback_queue_pkg.sv
// Shared writeback definitions: load funct3 encodings, GPR address width, access-size helper.
// Pure declarations; no latency and no flow control.
package wback_queue_pkg;

    localparam int GPR_AW = 5;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LD  = 3'b011,
        LBU = 3'b100,
        LHU = 3'b101,
        LWU = 3'b110
    } load_type_e;

    // log2 of the access size in bytes; the unsigned variants share the signed ones' low bits
    function automatic logic [1:0] load_size_log2(input logic [2:0] funct3);
        return funct3[1:0];
    endfunction

endpackage

// File: rtl/wback_load_fmt.sv
// Load formatter: byte-lane select plus sign/zero extension of a raw aligned memory word.
// Latency: purely combinational. Backpressure: none (no handshake).
module wback_load_fmt
    import wback_queue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]           mem_result_i,
    input  logic [2:0]                load_type_i,
    input  logic [$clog2(XLEN/8)-1:0] load_off_i,
    output logic [XLEN-1:0]           load_data_o
);

    localparam int OW = $clog2(XLEN/8);
    localparam int SW = $clog2(XLEN);

    logic [1:0]      size_log2;
    logic [OW-1:0]   lane_off;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] lane;

    always_comb begin
        size_log2   = load_size_log2(load_type_i);
        // Misaligned offsets are not trapped: the low offset bits are simply dropped.
        lane_off    = (load_off_i >> size_log2) << size_log2;
        shamt       = {lane_off, 3'b000};
        lane        = mem_result_i >> shamt;
        load_data_o = '0;
        case (load_type_i)
            LB:      load_data_o = XLEN'($signed(lane[7:0]));
            LH:      load_data_o = XLEN'($signed(lane[15:0]));
            LW:      load_data_o = XLEN'($signed(lane[31:0]));
            LBU:     load_data_o = XLEN'(lane[7:0]);
            LHU:     load_data_o = XLEN'(lane[15:0]);
            LD:      if (XLEN == 64) load_data_o = lane;
            LWU:     if (XLEN == 64) load_data_o = XLEN'(lane[31:0]);
            default: load_data_o = '0;
        endcase
    end

endmodule

// File: rtl/wback_queue.sv
// Writeback queue: DEPTH-entry FIFO from MEM to GPR/CSR write ports with RAW hazard report (forwarding under WBACK_QUEUE_BYPASS_EN).
// Latency: entry pushed at edge N is at the head from N+1; write strobes are combinational on the pop handshake.
// Backpressure: ready_pre_o = !full from registered count only; a full queue refuses pushes even when popping.
module wback_queue
    import wback_queue_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4,
    parameter int CSR_AW = 12
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      valid_pre_i,
    output logic                      ready_pre_o,
    output logic                      valid_post_o,
    input  logic                      ready_post_i,
    input  logic                      wsel_i,
    input  logic                      wena_i,
    input  logic [GPR_AW-1:0]         waddr_i,
    input  logic [XLEN-1:0]           alu_result_i,
    input  logic [XLEN-1:0]           mem_result_i,
    input  logic [2:0]                load_type_i,
    input  logic [$clog2(XLEN/8)-1:0] load_off_i,
    input  logic                      csr_wena_i,
    input  logic [CSR_AW-1:0]         csr_waddr_i,
    input  logic [XLEN-1:0]           csr_wdata_i,
    output logic                      wena_o,
    output logic [GPR_AW-1:0]         waddr_o,
    output logic [XLEN-1:0]           wdata_o,
    output logic                      csr_wena_o,
    output logic [CSR_AW-1:0]         csr_waddr_o,
    output logic [XLEN-1:0]           csr_wdata_o,
    input  logic [GPR_AW-1:0]         rs1_i,
    input  logic [GPR_AW-1:0]         rs2_i,
    output logic [1:0]                hazard_o,
`ifdef WBACK_QUEUE_BYPASS_EN
    output logic [XLEN-1:0]           fwd1_o,
    output logic [XLEN-1:0]           fwd2_o,
    output logic [1:0]                fwd_hit_o,
`endif
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic              wena;
        logic [GPR_AW-1:0] waddr;
        logic [XLEN-1:0]   wdata;
        logic              csr_wena;
        logic [CSR_AW-1:0] csr_waddr;
        logic [XLEN-1:0]   csr_wdata;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW:0]     count_q;

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    entry_t          head;
    entry_t          push_entry;
    logic [XLEN-1:0] load_data;
    logic [1:0]      rs_match;

    wback_load_fmt #(
        .XLEN (XLEN)
    ) u_load_fmt (
        .mem_result_i (mem_result_i),
        .load_type_i  (load_type_i),
        .load_off_i   (load_off_i),
        .load_data_o  (load_data)
    );

    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = valid_pre_i & ~full;
    assign pop   = ~empty & ready_post_i;

    always_comb begin
        push_entry           = '0;
        push_entry.wena      = wena_i & (waddr_i != '0);
        push_entry.waddr     = waddr_i;
        push_entry.wdata     = wsel_i ? load_data : alu_result_i;
        push_entry.csr_wena  = csr_wena_i;
        push_entry.csr_waddr = csr_waddr_i;
        push_entry.csr_wdata = csr_wdata_i;
    end

    // Push and pop never hit the same slot: that would need count 0 (no pop) or DEPTH (no push).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q        <= wr_ptr_q + PW'(1);
                vld_q[wr_ptr_q] <= 1'b1;
            end
            if (pop) begin
                rd_ptr_q        <= rd_ptr_q + PW'(1);
                vld_q[rd_ptr_q] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign head         = mem_q[rd_ptr_q];
    assign ready_pre_o  = ~full;
    assign valid_post_o = ~empty;
    assign count_o      = count_q;

    assign wena_o      = ~empty & head.wena & ready_post_i;
    assign csr_wena_o  = ~empty & head.csr_wena & ready_post_i;
    assign waddr_o     = empty ? '0 : head.waddr;
    assign wdata_o     = empty ? '0 : head.wdata;
    assign csr_waddr_o = empty ? '0 : head.csr_waddr;
    assign csr_wdata_o = empty ? '0 : head.csr_wdata;

`ifdef WBACK_QUEUE_BYPASS_EN
    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;
`endif
    logic [PW-1:0]   slot;

    // Scan oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        rs_match = '0;
        slot     = '0;
`ifdef WBACK_QUEUE_BYPASS_EN
        fwd1     = '0;
        fwd2     = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            slot = rd_ptr_q + PW'(k);
            if (vld_q[slot] && mem_q[slot].wena) begin
                if (rs1_i != '0 && mem_q[slot].waddr == rs1_i) begin
                    rs_match[0] = 1'b1;
`ifdef WBACK_QUEUE_BYPASS_EN
                    fwd1 = mem_q[slot].wdata;
`endif
                end
                if (rs2_i != '0 && mem_q[slot].waddr == rs2_i) begin
                    rs_match[1] = 1'b1;
`ifdef WBACK_QUEUE_BYPASS_EN
                    fwd2 = mem_q[slot].wdata;
`endif
                end
            end
        end
    end

`ifdef WBACK_QUEUE_BYPASS_EN
    // Every pending result already sits in the queue, so every match is forwardable.
    assign fwd_hit_o = rs_match;
    assign fwd1_o    = fwd1;
    assign fwd2_o    = fwd2;
    assign hazard_o  = rs_match & ~fwd_hit_o;
`else
    assign hazard_o  = rs_match;
`endif

endmodule
